// File: rtl/i2c_edid_slave_pkg.sv
// i2c_edid_slave_pkg: shared state encoding and constants for the DDC/EDID target
package i2c_edid_slave_pkg;
  localparam logic [6:0] DDC_ADDR_EDID = 7'h50;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int FILTER_LEN_DEF = 3;
  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, OFS, OFS_ACK, WR_NACK, RD_DATA, RD_ACK, IGNORE
  } state_t;
endpackage

// File: rtl/i2c_edid_slave_if.sv
// i2c_edid_slave_if: DDC pad signals plus the EDID ROM read port
interface i2c_edid_slave_if;
  logic       scl_i;
  logic       sda_i;
  logic       sda_oe;
  logic [7:0] rom_addr;
  logic [7:0] rom_data;
  logic       busy;
  modport slave (input scl_i, sda_i, rom_data, output sda_oe, rom_addr, busy);
  modport master (output scl_i, sda_i, rom_data, input sda_oe, rom_addr, busy);
endinterface

// File: rtl/i2c_in_filter.sv
// i2c_in_filter: 2-FF synchronizer, consecutive-sample glitch filter and edge pulses
module i2c_in_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic lvl,
  output logic rise,
  output logic fall
);
  localparam int CW = $clog2(FILTER_LEN + 1);
  logic s1, s2, take;
  logic [CW-1:0] cnt;
  assign take = (s2 != lvl) && (cnt == CW'(FILTER_LEN - 1));
  // accept a new level only after FILTER_LEN equal differing samples; pulses align with the level update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {s1, s2, lvl} <= 3'b111;
      cnt <= '0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      rise <= take & s2;
      fall <= take & ~s2;
      lvl <= take ? s2 : lvl;
      cnt <= (s2 != lvl && !take) ? cnt + 1'b1 : '0;
    end
  end
endmodule

// File: rtl/i2c_edid_slave.sv
// i2c_edid_slave: read-only DDC target serving the EDID ROM at address 0x50
module i2c_edid_slave
  import i2c_edid_slave_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = DDC_ADDR_EDID,
  parameter int FILTER_LEN = FILTER_LEN_DEF
) (
  input logic clk,
  input logic rst,
  i2c_edid_slave_if.slave bus
);
  logic scl_f, sda_f, scl_rise, scl_fall, sda_rise, sda_fall;
  logic start, stop, rw, sda_oe, busy;
  logic [2:0] bitc;
  logic [DATA_W-1:0] sh, rx;
  logic [ADDR_W-1:0] offset;
  state_t state;

  i2c_in_filter #(.FILTER_LEN(FILTER_LEN)) u_scl (
    .clk(clk), .rst(rst), .din(bus.scl_i), .lvl(scl_f), .rise(scl_rise), .fall(scl_fall)
  );
  i2c_in_filter #(.FILTER_LEN(FILTER_LEN)) u_sda (
    .clk(clk), .rst(rst), .din(bus.sda_i), .lvl(sda_f), .rise(sda_rise), .fall(sda_fall)
  );

  assign start = scl_f & sda_fall;
  assign stop = scl_f & sda_rise;
  assign rx = {sh[DATA_W-2:0], sda_f};
  assign bus.rom_addr = offset;
  assign bus.sda_oe = sda_oe;
  assign bus.busy = busy;

  // protocol FSM; in the ACK states the registered sda_oe tells the first fall (drive) from the second (release)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sh <= '0;
      offset <= '0;
      bitc <= '0;
      rw <= 1'b0;
      sda_oe <= 1'b0;
      busy <= 1'b0;
    end else if (start) begin
      state <= ADDR;
      bitc <= '0;
      sda_oe <= 1'b0;
    end else if (stop) begin
      state <= IDLE;
      sda_oe <= 1'b0;
      busy <= 1'b0;
    end else begin
      case (state)
        ADDR: if (scl_rise) begin
          sh <= rx;
          bitc <= bitc + 1'b1;
          if (bitc == 3'd7) begin
            state <= (rx[7:1] == DEV_ADDR) ? ADDR_ACK : IGNORE;
            busy <= rx[7:1] == DEV_ADDR;
            rw <= rx[0];
          end
        end
        ADDR_ACK: if (scl_fall) begin
          if (!sda_oe) sda_oe <= 1'b1;
          else begin
            sda_oe <= rw & ~bus.rom_data[7];
            sh <= bus.rom_data;
            state <= rw ? RD_DATA : OFS;
          end
        end
        OFS: if (scl_rise) begin
          sh <= rx;
          bitc <= bitc + 1'b1;
          if (bitc == 3'd7) begin
            offset <= rx;
            state <= OFS_ACK;
          end
        end
        OFS_ACK: if (scl_fall) begin
          sda_oe <= ~sda_oe;
          state <= sda_oe ? WR_NACK : OFS_ACK;
        end
        RD_DATA: if (scl_fall) begin
          bitc <= bitc + 1'b1;
          sh <= {sh[DATA_W-2:0], 1'b0};
          sda_oe <= (bitc == 3'd7) ? 1'b0 : ~sh[DATA_W-2];
          state <= (bitc == 3'd7) ? RD_ACK : RD_DATA;
        end
        RD_ACK: if (scl_rise) begin
          if (sda_f) begin
            state <= IGNORE;
            busy <= 1'b0;
          end else offset <= offset + 1'b1;
        end else if (scl_fall) begin
          sh <= bus.rom_data;
          sda_oe <= ~bus.rom_data[7];
          state <= RD_DATA;
        end
        IGNORE: begin
          sda_oe <= 1'b0;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule
